laser_point_feeder: RTL

// Host-side driver for the LASER circle-placement engine. It buffers one 40-point job from a host load port,

---
 rtl/laser_pkg.sv | 26 ++
 rtl/laser_in_circle.sv | 23 ++
 rtl/laser_point_feeder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/laser_pkg.sv
// Shared constants, FSM state encoding and coordinate helper for the LASER point feeder.
package laser_pkg;
    localparam int NPTS      = 40;
    localparam int RADIUS_SQ = 16;
    localparam int CW        = 4;
    localparam int TIMEOUT   = 4096;
    localparam int IDXW      = 6;
    localparam int TMOW      = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SEND,
        S_WAIT_LO,
        S_WAIT_HI,
        S_SCORE,
        S_REPORT
    } state_t;

    // Unsigned absolute difference of two coordinates, via a signed intermediate.
    function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic signed [CW:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? CW'(-d) : CW'(d);
    endfunction
endpackage

// File: rtl/laser_in_circle.sv
// Combinational test: is point (px,py) within RADIUS of centre (cx,cy).
module laser_in_circle
    import laser_pkg::*;
(
    input  logic [CW-1:0] px_i,
    input  logic [CW-1:0] py_i,
    input  logic [CW-1:0] cx_i,
    input  logic [CW-1:0] cy_i,
    output logic          hit_o
);
    localparam logic [2*CW:0] R_SQ = (2*CW+1)'(RADIUS_SQ);

    logic [CW-1:0]   dx, dy;
    logic [2*CW-1:0] dx2, dy2;
    logic [2*CW:0]   dist2;

    assign dx    = abs_diff(px_i, cx_i);
    assign dy    = abs_diff(py_i, cy_i);
    assign dx2   = {{CW{1'b0}}, dx} * {{CW{1'b0}}, dx};
    assign dy2   = {{CW{1'b0}}, dy} * {{CW{1'b0}}, dy};
    assign dist2 = {1'b0, dx2} + {1'b0, dy2};
    assign hit_o = (dist2 <= R_SQ);
endmodule

// File: rtl/laser_point_feeder.sv
// Buffers a job of points from the host, streams it to LASER, captures the returned
// circle centres and reports how many points fall inside either circle.
module laser_point_feeder
    import laser_pkg::*;
(
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          LD_VALID,
    input  logic [CW-1:0] LD_X,
    input  logic [CW-1:0] LD_Y,
    output logic          LD_READY,
    input  logic          LD_CLR,
    input  logic          START,
    output logic [CW-1:0] X,
    output logic [CW-1:0] Y,
    input  logic          DONE,
    input  logic [CW-1:0] C1X,
    input  logic [CW-1:0] C1Y,
    input  logic [CW-1:0] C2X,
    input  logic [CW-1:0] C2Y,
    output logic          BUSY,
    output logic [5:0]    SCORE,
    output logic          SCORE_VALID,
    output logic          ERR
);
    localparam logic [IDXW-1:0] FULL     = IDXW'(NPTS);
    localparam logic [IDXW-1:0] LAST     = IDXW'(NPTS - 1);
    localparam logic [TMOW-1:0] TMO_LAST = TMOW'(TIMEOUT - 1);

    state_t          state_q;
    logic [IDXW-1:0] wr_ptr_q, idx_q, idx_d;
    logic [TMOW-1:0] tmo_q;
    logic [5:0]      cnt_q, cnt_d;
    logic [CW-1:0]   c1x_q, c1y_q, c2x_q, c2y_q;
    logic [2*CW-1:0] buf_q [NPTS];
    logic [2*CW-1:0] pt;
    logic            full, wr_en, hit1, hit2;

    assign full     = (wr_ptr_q == FULL);
    assign LD_READY = (state_q == S_IDLE) && !full;
    assign wr_en    = LD_VALID && LD_READY && !LD_CLR;
    assign idx_d    = idx_q + 1'b1;
    assign pt       = buf_q[idx_q];
    assign cnt_d    = cnt_q + {5'd0, hit1 | hit2};

    laser_in_circle u_c1 (.px_i(pt[2*CW-1:CW]), .py_i(pt[CW-1:0]), .cx_i(c1x_q), .cy_i(c1y_q), .hit_o(hit1));
    laser_in_circle u_c2 (.px_i(pt[2*CW-1:CW]), .py_i(pt[CW-1:0]), .cx_i(c2x_q), .cy_i(c2y_q), .hit_o(hit2));

    // Point storage carries no reset; contents are only meaningful once loaded.
    always_ff @(posedge CLK) begin
        if (wr_en) buf_q[wr_ptr_q] <= {LD_X, LD_Y};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            cnt_q       <= '0;
            c1x_q       <= '0;
            c1y_q       <= '0;
            c2x_q       <= '0;
            c2y_q       <= '0;
            X           <= '0;
            Y           <= '0;
            BUSY        <= 1'b0;
            SCORE       <= '0;
            SCORE_VALID <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            SCORE_VALID <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (LD_CLR)     wr_ptr_q <= '0;
                    else if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (START && full) begin
                        state_q <= S_ARM;
                        BUSY    <= 1'b1;
                        ERR     <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (DONE) begin
                        state_q <= S_SEND;
                        idx_q   <= '0;
                        {X, Y}  <= buf_q[0];
                    end
                end
                // X/Y are pre-loaded one cycle ahead so buf[k] is on the pins during SEND cycle k.
                S_SEND: begin
                    if (idx_q == LAST) begin
                        state_q <= S_WAIT_LO;
                        {X, Y}  <= '0;
                        tmo_q   <= '0;
                    end else begin
                        idx_q  <= idx_d;
                        {X, Y} <= buf_q[idx_d];
                    end
                end
                S_WAIT_LO, S_WAIT_HI: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (state_q == S_WAIT_LO && !DONE) begin
                        state_q <= S_WAIT_HI;
                    end else if (state_q == S_WAIT_HI && DONE) begin
                        c1x_q   <= C1X;
                        c1y_q   <= C1Y;
                        c2x_q   <= C2X;
                        c2y_q   <= C2Y;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_SCORE;
                    end else if (tmo_q == TMO_LAST) begin
                        ERR         <= 1'b1;
                        SCORE       <= '0;
                        SCORE_VALID <= 1'b1;
                        BUSY        <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                S_SCORE: begin
                    cnt_q <= cnt_d;
                    if (idx_q == LAST) state_q <= S_REPORT;
                    else               idx_q   <= idx_d;
                end
                S_REPORT: begin
                    SCORE       <= cnt_q;
                    SCORE_VALID <= 1'b1;
                    BUSY        <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
